tank_lever_mapper: RTL and testbench



---
 rtl/tank_lever_mapper.sv | 218 +++++++++++++++++++++
 tb/tb_tank_lever_mapper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tank_lever_mapper.sv
// Joystick-to-tread lever mapper for the ultra_tank core: sync, debounce, map, reversal gap.
// Optional last-pressed-wins resolver per axis is built when TANK_LEVER_SOCD_EN is defined.

module tank_lever_channel #(
  parameter int DEBOUNCE_CYC = 12000,
  parameter int REVERSE_GAP  = 24000,
  parameter int CNT_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [3:0] joy_i,
  output logic [3:0] lever_o,
  output logic       changed_o
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_GAP = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REVERSE_GAP - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       resolved;
  logic [3:0]       target_q;
  logic [3:0]       applied_q, applied_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  state_e           state_q, state_d;
  logic             changed_q, changed_d;

  // {up,down,left,right} -> active-high {AFw,ABk,BFw,BBk}
  function automatic logic [3:0] map_dir(input logic [3:0] dir);
    case (dir)
      4'b1010: map_dir = 4'b0010;
      4'b1000: map_dir = 4'b1010;
      4'b1001: map_dir = 4'b1000;
      4'b0001: map_dir = 4'b1001;
      4'b0101: map_dir = 4'b0100;
      4'b0100: map_dir = 4'b0101;
      4'b0110: map_dir = 4'b0001;
      4'b0010: map_dir = 4'b0110;
      default: map_dir = 4'b0000;
    endcase
  endfunction

  function automatic logic reverses(input logic [3:0] cur, input logic [3:0] nxt);
    reverses = (cur[3] & nxt[2]) | (cur[2] & nxt[3]) |
               (cur[1] & nxt[0]) | (cur[0] & nxt[1]);
  endfunction

  // A bounce back to the stable value clears the count; any other value keeps counting.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef TANK_LEVER_SOCD_EN
  // Per-axis memory of the most recently risen bit: 2'b10 first, 2'b01 second, 2'b00 none.
  logic [1:0] last_v_q, last_v_d;
  logic [1:0] last_h_q, last_h_d;
  logic [3:0] rise;

  function automatic logic [1:0] next_last(input logic [1:0] r, input logic [1:0] last);
    if (r == 2'b10 || r == 2'b01) next_last = r;
    else                          next_last = last;
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] held, input logic [1:0] last);
    if (held == 2'b11 && last != 2'b00) pick = last;
    else                                pick = held;
  endfunction

  always_comb begin
    rise     = stable_d & ~stable_q;
    last_v_d = next_last(rise[3:2], last_v_q);
    last_h_d = next_last(rise[1:0], last_h_q);
    resolved = {pick(stable_q[3:2], last_v_q), pick(stable_q[1:0], last_h_q)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_v_q <= 2'b00;
      last_h_q <= 2'b00;
    end else begin
      last_v_q <= last_v_d;
      last_h_q <= last_h_d;
    end
  end
`else
  assign resolved = stable_q;
`endif

  // While in the gap, applied stays neutral so the exit value is taken without a reversal check.
  always_comb begin
    state_d   = state_q;
    applied_d = applied_q;
    gcnt_d    = gcnt_q;
    if (!enable_i) begin
      state_d   = ST_RUN;
      applied_d = 4'b0000;
      gcnt_d    = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (reverses(applied_q, target_q)) begin
            state_d   = ST_GAP;
            applied_d = 4'b0000;
            gcnt_d    = '0;
          end else begin
            applied_d = target_q;
          end
        end
        ST_GAP: begin
          if (gcnt_q == GAP_LAST) begin
            state_d   = ST_RUN;
            applied_d = target_q;
            gcnt_d    = '0;
          end else begin
            gcnt_d = gcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_RUN;
          applied_d = 4'b0000;
          gcnt_d    = '0;
        end
      endcase
    end
    changed_d = (applied_d != applied_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 4'b0000;
      sync2_q   <= 4'b0000;
      stable_q  <= 4'b0000;
      cnt_q     <= '0;
      target_q  <= 4'b0000;
      state_q   <= ST_RUN;
      applied_q <= 4'b0000;
      gcnt_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= joy_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      target_q  <= map_dir(resolved);
      state_q   <= state_d;
      applied_q <= applied_d;
      gcnt_q    <= gcnt_d;
      changed_q <= changed_d;
    end
  end

  assign lever_o   = ~applied_q;
  assign changed_o = changed_q;

endmodule

module tank_lever_mapper #(
  parameter int DEBOUNCE_CYC = 12000,
  parameter int REVERSE_GAP  = 24000,
  parameter int CNT_W        = 16
) (
  input  logic       Clk_I,
  input  logic       Reset_n,
  input  logic       Enable_I,
  input  logic [3:0] Joy1_I,
  input  logic [3:0] Joy2_I,
  output logic [3:0] LeverA_O,
  output logic [3:0] LeverB_O,
  output logic [1:0] Changed_O
);

  logic changed_a, changed_b;

  tank_lever_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REVERSE_GAP (REVERSE_GAP),
    .CNT_W       (CNT_W)
  ) u_chan_a (
    .clk_i    (Clk_I),
    .rst_ni   (Reset_n),
    .enable_i (Enable_I),
    .joy_i    (Joy1_I),
    .lever_o  (LeverA_O),
    .changed_o(changed_a)
  );

  tank_lever_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REVERSE_GAP (REVERSE_GAP),
    .CNT_W       (CNT_W)
  ) u_chan_b (
    .clk_i    (Clk_I),
    .rst_ni   (Reset_n),
    .enable_i (Enable_I),
    .joy_i    (Joy2_I),
    .lever_o  (LeverB_O),
    .changed_o(changed_b)
  );

  assign Changed_O = {changed_b, changed_a};

endmodule

// File: tb/tb_tank_lever_mapper.sv
// Scoreboard bench for tank_lever_mapper: each lever change is expected with its value and cycle stamp.
module tb_tank_lever_mapper;

  localparam int D   = 20;
  localparam int G   = 40;
  localparam int LAT = D + 4;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Enable_I;
  logic [3:0] Joy1_I, Joy2_I;
  logic [3:0] LeverA_O, LeverB_O;
  logic [1:0] Changed_O;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [35:0] exp_a_q[$];
  logic [35:0] exp_b_q[$];

  tank_lever_mapper #(
    .DEBOUNCE_CYC(D),
    .REVERSE_GAP (G),
    .CNT_W       (16)
  ) dut (
    .Clk_I    (clk),
    .Reset_n  (Reset_n),
    .Enable_I (Enable_I),
    .Joy1_I   (Joy1_I),
    .Joy2_I   (Joy2_I),
    .LeverA_O (LeverA_O),
    .LeverB_O (LeverB_O),
    .Changed_O(Changed_O)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_a(input logic [3:0] v, input int stamp);
    exp_a_q.push_back({32'(stamp), v});
  endtask

  task automatic expect_b(input logic [3:0] v, input int stamp);
    exp_b_q.push_back({32'(stamp), v});
  endtask

  // monitor: every Changed_O pulse must match the next expected value at its expected cycle
  always @(negedge clk) begin
    logic [35:0] e;
    if (Reset_n) begin
      if (Changed_O[0]) begin
        if (exp_a_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL chA_unexpected: LeverA_O=%b at cycle %0d, no change expected", LeverA_O, cyc);
        end else begin
          e = exp_a_q.pop_front();
          check("chA_value", 32'(LeverA_O), 32'(e[3:0]));
          check("chA_cycle", 32'(cyc), e[35:4]);
        end
      end
      if (Changed_O[1]) begin
        if (exp_b_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL chB_unexpected: LeverB_O=%b at cycle %0d, no change expected", LeverB_O, cyc);
        end else begin
          e = exp_b_q.pop_front();
          check("chB_value", 32'(LeverB_O), 32'(e[3:0]));
          check("chB_cycle", 32'(cyc), e[35:4]);
        end
      end
    end
  end

  initial begin
    int c0;
    Reset_n  = 1'b0;
    Enable_I = 1'b1;
    Joy1_I   = 4'b0000;
    Joy2_I   = 4'b0000;
    #2;
    check("rst_leverA", 32'(LeverA_O), 32'(4'b1111));
    check("rst_leverB", 32'(LeverB_O), 32'(4'b1111));
    check("rst_changed", 32'(Changed_O), 32'(2'b00));
    wait_cyc(3);
    Reset_n = 1'b1;
    wait_cyc(2);

    // up from neutral: exact debounce latency
    Joy1_I = 4'b1000; expect_a(4'b0101, cyc + LAT);
    wait_cyc(40);
    check("idle_leverB", 32'(LeverB_O), 32'(4'b1111));

    // back to neutral, then glitchy up that never settles long enough
    Joy1_I = 4'b0000; expect_a(4'b1111, cyc + LAT);
    wait_cyc(40);
    for (int i = 0; i < 5; i++) begin
      Joy1_I = 4'b1000; wait_cyc(10);
      Joy1_I = 4'b0000; wait_cyc(3);
    end
    check("glitch_hold", 32'(LeverA_O), 32'(4'b1111));
    Joy1_I = 4'b1000; expect_a(4'b0101, cyc + LAT);
    wait_cyc(40);

    // up -> down reverses: neutral gap; left arriving mid-gap does not stretch it
    Joy1_I = 4'b0100; c0 = cyc;
    expect_a(4'b1111, c0 + LAT);
    expect_a(4'b1001, c0 + LAT + G);
    wait_cyc(30);
    Joy1_I = 4'b0010;
    wait_cyc(50);

    // non-reversing changes apply immediately
    Joy1_I = 4'b1010; expect_a(4'b1101, cyc + LAT);
    wait_cyc(40);
    Joy1_I = 4'b1000; expect_a(4'b0101, cyc + LAT);
    wait_cyc(40);

    // disable forces neutral next edge; re-enable applies held down with no gap
    Enable_I = 1'b0; Joy1_I = 4'b0100; expect_a(4'b1111, cyc + 1);
    wait_cyc(40);
    check("disabled_hold", 32'(LeverA_O), 32'(4'b1111));
    Enable_I = 1'b1; expect_a(4'b1010, cyc + 1);
    wait_cyc(40);

    // channel B independent
    Joy2_I = 4'b0100; expect_b(4'b1010, cyc + LAT);
    wait_cyc(40);
    Joy2_I = 4'b0110; expect_b(4'b1110, cyc + LAT);
    wait_cyc(40);

    // opposing up+down on channel A
    Joy1_I = 4'b1000; c0 = cyc;
    expect_a(4'b1111, c0 + LAT);
    expect_a(4'b0101, c0 + LAT + G);
    wait_cyc(80);
    Joy1_I = 4'b1100; c0 = cyc;
`ifdef TANK_LEVER_SOCD_EN
    expect_a(4'b1111, c0 + LAT);
    expect_a(4'b1010, c0 + LAT + G);
`else
    expect_a(4'b1111, c0 + LAT);
`endif
    wait_cyc(80);
    Joy1_I = 4'b1000; c0 = cyc;
`ifdef TANK_LEVER_SOCD_EN
    expect_a(4'b1111, c0 + LAT);
    expect_a(4'b0101, c0 + LAT + G);
`else
    expect_a(4'b0101, c0 + LAT);
`endif
    wait_cyc(80);

    // reset in the middle of a gap on channel B
    Joy2_I = 4'b1000; expect_b(4'b1111, cyc + LAT);
    wait_cyc(30);
    Reset_n = 1'b0; Joy1_I = 4'b0000; Joy2_I = 4'b0000;
    #1;
    check("midgap_rst_leverA", 32'(LeverA_O), 32'(4'b1111));
    check("midgap_rst_leverB", 32'(LeverB_O), 32'(4'b1111));
    check("midgap_rst_changed", 32'(Changed_O), 32'(2'b00));
    wait_cyc(3);
    Reset_n = 1'b1;
    wait_cyc(2);
    Joy2_I = 4'b0100; expect_b(4'b1010, cyc + LAT);
    wait_cyc(80);

    check("chA_pending", 32'(exp_a_q.size()), 32'd0);
    check("chB_pending", 32'(exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
